// File: rtl/ps2_scancode_fifo.sv
// PS/2 scancode front end: takes raw bytes from a PS/2 receiver, folds the
// E0/F0 prefix bytes into {brk,ext,code} entries, queues them in a small FIFO
// and exposes the queue to a CPU through an 8-bit bidirectional bus with a
// data register (a=0) and a status register (a=1).
module ps2_scancode_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_parity_ok,
    output logic       in_ack,
    inout  wire  [7:0] d,
    input  logic       n_sel,
    input  logic       n_oe,
    input  logic       n_we,
    input  logic       a,
    output logic       irq
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_E0   = 2'd1,
        ST_F0   = 2'd2,
        ST_E0F0 = 2'd3
    } state_t;

    // Receiver handshake and prefix tracking
    state_t          r_state;
    logic            r_armed;
    logic            r_in_ack;

    // Queue storage and bookkeeping
    logic [9:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_ovf;
    logic            r_perr;
    logic            r_irq;
    logic            r_we_prev;

    state_t          w_state_next;
    logic            w_capture;
    logic            w_bad_parity;
    logic            w_push;
    logic [9:0]      w_entry;
    logic            w_full;
    logic            w_nempty;
    logic            w_wr_active;
    logic            w_wr_strobe;
    logic            w_pop;
    logic            w_push_ok;
    logic            w_ovf_set;
    logic            w_ovf_clr;
    logic            w_perr_clr;
    logic [CW-1:0]   w_count_next;
    logic [9:0]      w_head;
    logic [7:0]      w_status;
    logic [7:0]      w_rd_data;
    logic            w_drive;

    // A byte is taken once per in_valid assertion; armed drops on capture.
    assign w_capture    = in_valid & r_armed;
    assign w_bad_parity = w_capture & ~in_parity_ok;

    // Prefix decoder: decides the next prefix state and whether this byte
    // produces a queue entry.
    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        w_entry      = {2'b00, in_data};
        if (w_capture) begin
            if (!in_parity_ok) begin
                w_state_next = ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (in_data == 8'hE0) begin
                            w_state_next = ST_E0;
                        end else if (in_data == 8'hF0) begin
                            w_state_next = ST_F0;
                        end else begin
                            w_push  = 1'b1;
                            w_entry = {2'b00, in_data};
                        end
                    end
                    ST_E0: begin
                        if (in_data == 8'hF0) begin
                            w_state_next = ST_E0F0;
                        end else if (in_data == 8'hE0) begin
                            w_state_next = ST_E0;
                        end else begin
                            w_push       = 1'b1;
                            w_entry      = {2'b01, in_data};
                            w_state_next = ST_IDLE;
                        end
                    end
                    ST_F0: begin
                        w_state_next = ST_IDLE;
                        if (in_data != 8'hE0 && in_data != 8'hF0) begin
                            w_push  = 1'b1;
                            w_entry = {2'b10, in_data};
                        end
                    end
                    ST_E0F0: begin
                        w_state_next = ST_IDLE;
                        if (in_data != 8'hE0 && in_data != 8'hF0) begin
                            w_push  = 1'b1;
                            w_entry = {2'b11, in_data};
                        end
                    end
                    default: w_state_next = ST_IDLE;
                endcase
            end
        end
    end

    // CPU write detection: only the first cycle of a write strobe acts.
    assign w_wr_active = ~n_sel & ~n_we;
    assign w_wr_strobe = w_wr_active & ~r_we_prev;

    assign w_nempty  = (r_count != '0);
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_pop     = w_wr_strobe & ~a & w_nempty;
    // A pop in the same cycle frees the slot, so a push into a full queue is kept.
    assign w_push_ok = w_push & (~w_full | w_pop);
    assign w_ovf_set = w_push & w_full & ~w_pop;
    assign w_ovf_clr  = w_wr_strobe & a & d[3];
    assign w_perr_clr = w_wr_strobe & a & d[4];

    // Occupancy after this cycle's push/pop, also used to register irq.
    always_comb begin
        w_count_next = r_count;
        case ({w_push_ok, w_pop})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Handshake and prefix state machine with registered in_ack.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state  <= ST_IDLE;
            r_armed  <= 1'b1;
            r_in_ack <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_in_ack <= w_capture;
            if (w_capture) begin
                r_armed <= 1'b0;
            end else if (!in_valid) begin
                r_armed <= 1'b1;
            end
        end
    end

    // Queue storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    // Pointers, occupancy, sticky status flags and interrupt.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
            r_perr    <= 1'b0;
            r_irq     <= 1'b0;
            r_we_prev <= 1'b0;
        end else begin
            r_we_prev <= w_wr_active;
            r_count   <= w_count_next;
            r_irq     <= (w_count_next != '0);
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            // Setting wins over a same-cycle clear so no event is lost.
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
            if (w_bad_parity) begin
                r_perr <= 1'b1;
            end else if (w_perr_clr) begin
                r_perr <= 1'b0;
            end
        end
    end

    // Bus read path: head fields read as zero when the queue is empty.
    assign w_head    = r_mem[r_rd_ptr];
    assign w_status  = {3'b000, r_perr, r_ovf,
                        w_nempty & w_head[8], w_nempty & w_head[9], w_nempty};
    assign w_rd_data = a ? w_status : (w_nempty ? w_head[7:0] : 8'h00);
    assign w_drive   = ~n_sel & ~n_oe & n_we;
    assign d         = w_drive ? w_rd_data : 8'hzz;

    assign in_ack = r_in_ack;
    assign irq    = r_irq;

endmodule

// File: tb/tb_ps2_scancode_fifo.sv
// Bench for ps2_scancode_fifo: a table of byte/expectation rows, a reference
// prefix model feeding a scoreboard queue, and hand-written multi-cycle cases
// (overflow, held strobes, simultaneous push/pop, resets mid-sequence).
module tb_ps2_scancode_fifo;

    localparam int DEPTH = 8;
    localparam int S_IDLE = 0;
    localparam int S_E0   = 1;
    localparam int S_F0   = 2;
    localparam int S_EF   = 3;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_parity_ok;
    logic       in_ack;
    wire  [7:0] d;
    logic       n_sel;
    logic       n_oe;
    logic       n_we;
    logic       a;
    logic       irq;
    logic [7:0] tb_d;
    logic       tb_d_en;

    assign d = tb_d_en ? tb_d : 8'hzz;

    always #5 clk = ~clk;

    ps2_scancode_fifo #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_parity_ok (in_parity_ok),
        .in_ack       (in_ack),
        .d            (d),
        .n_sel        (n_sel),
        .n_oe         (n_oe),
        .n_we         (n_we),
        .a            (a),
        .irq          (irq)
    );

    int checks   = 0;
    int failures = 0;
    int ack_cnt  = 0;

    // Reference model state
    logic [9:0] exp_q[$];
    int         m_state;
    logic       m_ovf;
    logic       m_perr;

    typedef struct {
        logic [7:0] b;
        logic       par;
        logic       pop;
        logic [7:0] st;
        logic [7:0] dat;
    } vec_t;
    vec_t vecs[$];

    always @(negedge clk) if (in_ack) ack_cnt++;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_state = S_IDLE;
        m_ovf   = 1'b0;
        m_perr  = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b, input logic par);
        logic       do_push = 1'b0;
        logic [9:0] e = '0;
        if (!par) begin
            m_perr  = 1'b1;
            m_state = S_IDLE;
            return;
        end
        case (m_state)
            S_IDLE: begin
                if (b == 8'hE0) m_state = S_E0;
                else if (b == 8'hF0) m_state = S_F0;
                else begin do_push = 1'b1; e = {2'b00, b}; end
            end
            S_E0: begin
                if (b == 8'hF0) m_state = S_EF;
                else if (b != 8'hE0) begin do_push = 1'b1; e = {2'b01, b}; m_state = S_IDLE; end
            end
            S_F0: begin
                m_state = S_IDLE;
                if (b != 8'hE0 && b != 8'hF0) begin do_push = 1'b1; e = {2'b10, b}; end
            end
            default: begin
                m_state = S_IDLE;
                if (b != 8'hE0 && b != 8'hF0) begin do_push = 1'b1; e = {2'b11, b}; end
            end
        endcase
        if (do_push) begin
            if (exp_q.size() == DEPTH) m_ovf = 1'b1;
            else exp_q.push_back(e);
        end
    endtask

    function automatic logic [7:0] exp_status();
        logic [7:0] s;
        s = {3'b000, m_perr, m_ovf, 3'b000};
        if (exp_q.size() > 0) s = s | {5'b00000, exp_q[0][8], exp_q[0][9], 1'b1};
        return s;
    endfunction

    task automatic bus_read(input logic av, output logic [7:0] v);
        @(negedge clk);
        a = av; tb_d_en = 1'b0; n_we = 1'b1; n_sel = 1'b0; n_oe = 1'b0;
        #1 v = d;
        #1 n_sel = 1'b1; n_oe = 1'b1;
    endtask

    task automatic bus_write(input logic av, input logic [7:0] v);
        @(negedge clk);
        a = av; tb_d = v; tb_d_en = 1'b1; n_oe = 1'b1; n_sel = 1'b0; n_we = 1'b0;
        @(negedge clk);
        n_sel = 1'b1; n_we = 1'b1; tb_d_en = 1'b0;
    endtask

    // Present a byte until acknowledged, then release and update the model.
    task automatic send_byte(input logic [7:0] b, input logic par);
        bit got = 1'b0;
        @(negedge clk);
        in_data = b; in_parity_ok = par; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (in_ack) begin got = 1'b1; break; end
        end
        in_valid = 1'b0;
        chk("ack_seen", {15'd0, got}, 16'd1);
        @(negedge clk);
        chk("ack_width", {15'd0, in_ack}, 16'd0);
        model_byte(b, par);
    endtask

    // Compare head and status with the scoreboard, then pop one entry.
    task automatic pop_check(input string name);
        logic [7:0] st, dt;
        bus_read(1'b1, st);
        bus_read(1'b0, dt);
        chk({name, "_status"}, {8'd0, st}, {8'd0, exp_status()});
        chk({name, "_irq"}, {15'd0, irq}, {15'd0, exp_q.size() > 0});
        if (exp_q.size() > 0) begin
            chk({name, "_data"}, {8'd0, dt}, {8'd0, exp_q[0][7:0]});
            bus_write(1'b0, 8'h00);
            void'(exp_q.pop_front());
        end
    endtask

    initial begin
        logic [7:0] st, dt;
        int         base;

        vecs.push_back('{8'h1C, 1'b1, 1'b1, 8'h01, 8'h1C});
        vecs.push_back('{8'hE0, 1'b1, 1'b0, 8'h00, 8'h00});
        vecs.push_back('{8'hF0, 1'b1, 1'b0, 8'h00, 8'h00});
        vecs.push_back('{8'h75, 1'b1, 1'b1, 8'h07, 8'h75});
        vecs.push_back('{8'hF0, 1'b1, 1'b0, 8'h00, 8'h00});
        vecs.push_back('{8'h1C, 1'b1, 1'b1, 8'h03, 8'h1C});
        vecs.push_back('{8'hE0, 1'b1, 1'b0, 8'h00, 8'h00});
        vecs.push_back('{8'h6B, 1'b1, 1'b1, 8'h05, 8'h6B});
        vecs.push_back('{8'hE0, 1'b1, 1'b0, 8'h00, 8'h00});
        vecs.push_back('{8'hE0, 1'b1, 1'b0, 8'h00, 8'h00});
        vecs.push_back('{8'h72, 1'b1, 1'b1, 8'h05, 8'h72});
        vecs.push_back('{8'hF0, 1'b1, 1'b0, 8'h00, 8'h00});
        vecs.push_back('{8'hE0, 1'b1, 1'b0, 8'h00, 8'h00});
        vecs.push_back('{8'h29, 1'b1, 1'b1, 8'h01, 8'h29});
        vecs.push_back('{8'hE0, 1'b1, 1'b0, 8'h00, 8'h00});
        vecs.push_back('{8'hF0, 1'b1, 1'b0, 8'h00, 8'h00});
        vecs.push_back('{8'hF0, 1'b1, 1'b0, 8'h00, 8'h00});
        vecs.push_back('{8'h1C, 1'b1, 1'b1, 8'h01, 8'h1C});
        vecs.push_back('{8'hE0, 1'b1, 1'b0, 8'h00, 8'h00});
        vecs.push_back('{8'h5A, 1'b0, 1'b0, 8'h10, 8'h00});
        vecs.push_back('{8'h5A, 1'b1, 1'b1, 8'h11, 8'h5A});

        n_rst = 1'b0; in_data = 8'h00; in_valid = 1'b0; in_parity_ok = 1'b1;
        n_sel = 1'b1; n_oe = 1'b1; n_we = 1'b1; a = 1'b0; tb_d = 8'h00; tb_d_en = 1'b0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ack", {15'd0, in_ack}, 16'd0);
        chk("rst_irq", {15'd0, irq}, 16'd0);
        bus_read(1'b1, st);
        chk("rst_status", {8'd0, st}, 16'h0000);
        @(negedge clk);
        n_rst = 1'b1;
        bus_read(1'b1, st);
        chk("post_rst_status", {8'd0, st}, 16'h0000);

        // Table-driven byte sequences
        for (int i = 0; i < vecs.size(); i++) begin
            send_byte(vecs[i].b, vecs[i].par);
            bus_read(1'b1, st);
            bus_read(1'b0, dt);
            $display("vec %0d byte=0x%0h par=%0b status=0x%0h data=0x%0h", i, vecs[i].b, vecs[i].par, st, dt);
            chk($sformatf("vec%0d_status", i), {8'd0, st}, {8'd0, vecs[i].st});
            chk($sformatf("vec%0d_data", i), {8'd0, dt}, {8'd0, vecs[i].dat});
            chk($sformatf("vec%0d_irq", i), {15'd0, irq}, {15'd0, vecs[i].st[0]});
            if (vecs[i].pop) pop_check($sformatf("vec%0d_pop", i));
        end
        bus_write(1'b1, 8'h10);
        m_perr = 1'b0;
        bus_read(1'b1, st);
        chk("perr_clear", {8'd0, st}, 16'h0000);

        // Overflow: nine bytes into eight slots
        for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b1);
        bus_read(1'b1, st);
        bus_read(1'b0, dt);
        $display("overflow status=0x%0h head=0x%0h", st, dt);
        chk("ovf_status", {8'd0, st}, 16'h0009);
        chk("ovf_head", {8'd0, dt}, 16'h0001);
        bus_write(1'b1, 8'h08);
        m_ovf = 1'b0;
        bus_read(1'b1, st);
        chk("ovf_clear", {8'd0, st}, 16'h0001);
        for (int i = 0; i < DEPTH; i++) pop_check($sformatf("ovf_pop%0d", i));
        bus_read(1'b1, st);
        chk("ovf_drained", {8'd0, st}, 16'h0000);
        chk("ovf_drained_irq", {15'd0, irq}, 16'd0);

        // Held in_valid captured once; held n_we pops once
        send_byte(8'h33, 1'b1);
        base = ack_cnt;
        @(negedge clk);
        in_data = 8'h29; in_parity_ok = 1'b1; in_valid = 1'b1;
        repeat (20) @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        $display("held valid ack pulses=%0d", ack_cnt - base);
        chk("held_valid_acks", 16'(ack_cnt - base), 16'd1);
        model_byte(8'h29, 1'b1);
        @(negedge clk);
        a = 1'b0; tb_d = 8'h00; tb_d_en = 1'b1; n_sel = 1'b0; n_we = 1'b0;
        repeat (10) @(negedge clk);
        n_sel = 1'b1; n_we = 1'b1; tb_d_en = 1'b0;
        void'(exp_q.pop_front());
        bus_read(1'b0, dt);
        $display("held n_we head=0x%0h", dt);
        chk("held_we_head", {8'd0, dt}, 16'h0029);
        pop_check("held_we_pop");
        bus_read(1'b1, st);
        chk("held_we_empty", {8'd0, st}, 16'h0000);

        // Same-cycle push and pop while full
        for (int i = 0; i < DEPTH; i++) send_byte(8'h40 + 8'(i), 1'b1);
        @(negedge clk);
        in_data = 8'h48; in_parity_ok = 1'b1; in_valid = 1'b1;
        a = 1'b0; tb_d = 8'h00; tb_d_en = 1'b1; n_sel = 1'b0; n_we = 1'b0;
        @(negedge clk);
        n_sel = 1'b1; n_we = 1'b1; tb_d_en = 1'b0; in_valid = 1'b0;
        chk("pp_ack", {15'd0, in_ack}, 16'd1);
        @(negedge clk);
        void'(exp_q.pop_front());
        model_byte(8'h48, 1'b1);
        bus_read(1'b1, st);
        bus_read(1'b0, dt);
        $display("push+pop full status=0x%0h head=0x%0h", st, dt);
        chk("pp_status", {8'd0, st}, 16'h0001);
        chk("pp_head", {8'd0, dt}, 16'h0041);
        for (int i = 0; i < DEPTH; i++) pop_check($sformatf("pp_pop%0d", i));
        bus_read(1'b1, st);
        chk("pp_empty", {8'd0, st}, 16'h0000);

        // Reset after E0 prefix with three entries queued
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'hE0, 1'b1);
        chk("pre_rst_irq", {15'd0, irq}, 16'd1);
        @(negedge clk);
        #3 n_rst = 1'b0;
        #1 chk("async_rst_irq", {15'd0, irq}, 16'd0);
        @(negedge clk);
        n_rst = 1'b1;
        model_reset();
        bus_read(1'b1, st);
        $display("reset after E0 status=0x%0h", st);
        chk("rst_e0_status", {8'd0, st}, 16'h0000);
        send_byte(8'h6B, 1'b1);
        bus_read(1'b1, st);
        chk("rst_6b_status", {8'd0, st}, 16'h0001);
        pop_check("rst_6b_pop");

        // Reset during the in_ack pulse; byte still valid afterwards
        @(negedge clk);
        in_data = 8'h4B; in_parity_ok = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        chk("ack_before_rst", {15'd0, in_ack}, 16'd1);
        #2 n_rst = 1'b0;
        #1 chk("ack_cut_by_rst", {15'd0, in_ack}, 16'd0);
        base = ack_cnt;
        model_reset();
        @(negedge clk);
        n_rst = 1'b1;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        $display("reset during ack: pulses after release=%0d", ack_cnt - base);
        chk("rst_ack_recapture", 16'(ack_cnt - base), 16'd1);
        model_byte(8'h4B, 1'b1);
        pop_check("rst_ack_pop");
        bus_read(1'b1, st);
        chk("final_empty", {8'd0, st}, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ps2_scancode_fifo.md
PS2_SCANCODE_FIFO -- requirements
Module: ps2_scancode_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entry count (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_data  input  8  byte from PS/2 receiver.
REQ-005 SHALL have port in_valid  input  1  high while receiver holds an unconsumed byte.
REQ-006 SHALL have port in_parity_ok  input  1  parity of held byte valid; qualified by in_valid.
REQ-007 SHALL have port in_ack  output  1  one-cycle pulse: byte consumed, receiver may re-arm.
REQ-008 SHALL have port d  inout  8  CPU data bus.
REQ-009 SHALL have port n_sel  input  1  chip select, active-low.
REQ-010 SHALL have port n_oe  input  1  read strobe, active-low.
REQ-011 SHALL have port n_we  input  1  write strobe, active-low.
REQ-012 SHALL have port a  input  1  register select: 0 data, 1 status.
REQ-013 SHALL have port irq  output  1  high while FIFO not empty.

Function
REQ-014 SHALL capture in_data when in_valid=1 and armed; capture clears armed and pulses in_ack for exactly one cycle on the next cycle.
REQ-015 SHALL re-arm only after in_valid sampled 0; a byte held high across cycles SHALL be captured once.
REQ-016 SHALL drop a captured byte with in_parity_ok=0, set status perr, return prefix FSM to IDLE, still pulse in_ack.
REQ-017 SHALL run prefix FSM IDLE, E0, F0, E0F0 on each parity-valid byte.
REQ-018 IDLE: 0xE0 -> E0; 0xF0 -> F0; other byte b -> push {brk=0,ext=0,b}, stay IDLE.
REQ-019 E0: 0xF0 -> E0F0; 0xE0 -> stay E0; other b -> push {0,1,b}, -> IDLE.
REQ-020 F0: 0xE0 or 0xF0 -> IDLE, no push; other b -> push {1,0,b}, -> IDLE.
REQ-021 E0F0: 0xE0 or 0xF0 -> IDLE, no push; other b -> push {1,1,b}, -> IDLE.
REQ-022 SHALL store 10-bit entries {brk,ext,code[7:0]}; push visible at head one cycle after capture.
REQ-023 SHALL, on push while full with no same-cycle pop, drop the entry and set status ovf.
REQ-024 SHALL, on same-cycle push and pop, perform both; when full, push accepted (count unchanged).
REQ-025 SHALL ignore pop when empty; pointers wrap modulo DEPTH; count width log2(DEPTH)+1.
REQ-026 SHALL drive d only when n_sel=0, n_oe=0, n_we=1; else d=z (combinational).
REQ-027 a=0 read SHALL return head code (0x00 when empty); a=1 read SHALL return {3'b0,perr,ovf,ext,brk,nempty}, head fields 0 when empty.
REQ-028 SHALL treat bus inputs as synchronous to clk; a write is the first cycle n_sel=0 and n_we=0 after a cycle without both (one action per strobe).
REQ-029 Write a=0 SHALL pop one entry; write a=1 SHALL clear ovf if d[3]=1 and perr if d[4]=1.
REQ-030 Flag set and clear in same cycle SHALL leave flag set.
REQ-031 irq SHALL equal nempty, registered.

Reset
REQ-032 n_rst=0 SHALL immediately clear FIFO, count, pointers, ovf, perr, irq, in_ack, set FSM IDLE, armed=1.
REQ-033 Reset mid-sequence (after E0/F0, during in_ack pulse) SHALL discard prefix and pending byte; a byte still valid after release SHALL be captured once.

Verification
REQ-034 Bytes 0x1C -> status 0x01, data 0x1C, in_ack one pulse; pop -> status 0x00, irq 0.
REQ-035 Sequence E0 F0 75 -> one entry, status 0x07, data 0x75; F0 1C -> status 0x03.
REQ-036 Nine bytes 0x01..0x09 into DEPTH=8 -> count 8, ovf set, head 0x01, 0x09 lost; write a=1 d=0x08 -> ovf clear.
REQ-037 Byte 0xE0 then 0x5A with in_parity_ok=0, then 0x5A valid -> perr=1, one entry {0,0,0x5A}.
REQ-038 in_valid held 20 cycles with 0x29 -> exactly one push and one in_ack pulse; n_we held low 10 cycles -> exactly one pop.
REQ-039 n_rst pulsed after E0 with 3 entries queued -> status 0x00, next 0x6B pushes {0,0,0x6B}.
